// File: rtl/pacman_pkg.sv
// Shared Pac-Man movement types: direction enum, HID keycodes and unit-step helpers.
package pacman_pkg;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } dir_t;

  localparam logic [7:0] KEY_UP    = 8'h1A;
  localparam logic [7:0] KEY_DOWN  = 8'h16;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;

  typedef struct packed {
    logic signed [9:0] dx;
    logic signed [9:0] dy;
  } unit_t;

  // Screen coordinates: UP decreases Y.
  function automatic unit_t dir_unit(input dir_t d);
    unit_t u;
    u.dx = '0;
    u.dy = '0;
    case (d)
      UP:      u.dy = -10'sd1;
      DOWN:    u.dy = 10'sd1;
      LEFT:    u.dx = -10'sd1;
      RIGHT:   u.dx = 10'sd1;
      default: ;
    endcase
    return u;
  endfunction

  function automatic dir_t key_to_dir(input logic [7:0] key);
    dir_t d;
    case (key)
      KEY_UP:    d = UP;
      KEY_DOWN:  d = DOWN;
      KEY_LEFT:  d = LEFT;
      KEY_RIGHT: d = RIGHT;
      default:   d = NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pacman_move_ctrl_tick.sv
// step_tick_gen: free-running divider, one-cycle tick on the wrap cycle of 0..DIV-1.
module step_tick_gen #(
  parameter int unsigned DIV = 833333
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else if (tick)
      cnt <= '0;
    else
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/pacman_move_ctrl.sv
// Pac-Man movement sequencer: per-step wall queries and position/motion update.
// Optional PACMAN_TUNNEL_WRAP_EN: horizontal targets past X_MIN/X_MAX wrap to the opposite edge.
module pacman_move_ctrl
  import pacman_pkg::*;
#(
  parameter int unsigned STEP_DIV = 833333,
  parameter logic [9:0]  START_X  = 10'd320,
  parameter logic [9:0]  START_Y  = 10'd360,
  parameter logic [9:0]  X_MIN    = 10'd8,
  parameter logic [9:0]  X_MAX    = 10'd631
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] keycode,
  input  logic       won,
  output logic       wq_valid,
  output logic [9:0] wq_x,
  output logic [9:0] wq_y,
  input  logic       wq_ready,
  input  logic       wq_wall,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [9:0] motion_x,
  output logic [9:0] motion_y,
  output logic       step_strobe
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    Q_WANT = 2'd1,
    Q_CUR  = 2'd2,
    MOVE   = 2'd3
  } state_t;

  state_t     state, state_n;
  dir_t       cur_dir, cur_dir_n, want_dir;
  logic [9:0] pos_x_n, pos_y_n, motion_x_n, motion_y_n;
  logic       step_strobe_n;
  logic       tick;

  step_tick_gen #(.DIV(STEP_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // Target tile for the direction relevant to the current state.
  dir_t       q_dir;
  unit_t      q_unit;
  logic [9:0] raw_x, tgt_x, tgt_y;
  logic       x_oob;
  logic       in_query;

  always_comb begin
    q_dir  = (state == Q_WANT) ? want_dir : cur_dir;
    q_unit = dir_unit(q_dir);
    raw_x  = pos_x + q_unit.dx;
    tgt_y  = pos_y + q_unit.dy;
`ifdef PACMAN_TUNNEL_WRAP_EN
    x_oob = 1'b0;
    if (raw_x > X_MAX)
      tgt_x = X_MIN;
    else if (raw_x < X_MIN)
      tgt_x = X_MAX;
    else
      tgt_x = raw_x;
`else
    x_oob = (raw_x > X_MAX) || (raw_x < X_MIN);
    tgt_x = raw_x;
`endif
  end

  assign in_query = (state == Q_WANT) || (state == Q_CUR);
  assign wq_valid = in_query && !x_oob;
  assign wq_x     = wq_valid ? tgt_x : '0;
  assign wq_y     = wq_valid ? tgt_y : '0;

  // An out-of-range X resolves the query at once as a wall, without a handshake.
  logic resolved, hit;
  assign resolved = x_oob || (wq_valid && wq_ready);
  assign hit      = x_oob || wq_wall;

  always_comb begin
    state_n       = state;
    cur_dir_n     = cur_dir;
    pos_x_n       = pos_x;
    pos_y_n       = pos_y;
    motion_x_n    = motion_x;
    motion_y_n    = motion_y;
    step_strobe_n = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          if (won) begin
            motion_x_n = '0;
            motion_y_n = '0;
          end else if (want_dir != NONE && want_dir != cur_dir) begin
            state_n = Q_WANT;
          end else if (cur_dir != NONE) begin
            state_n = Q_CUR;
          end
        end
      end
      Q_WANT: begin
        if (resolved) begin
          if (won) begin
            motion_x_n = '0;
            motion_y_n = '0;
            state_n    = IDLE;
          end else if (!hit) begin
            cur_dir_n = want_dir;
            state_n   = MOVE;
          end else if (cur_dir != NONE) begin
            state_n = Q_CUR;
          end else begin
            motion_x_n = '0;
            motion_y_n = '0;
            state_n    = IDLE;
          end
        end
      end
      Q_CUR: begin
        if (resolved) begin
          if (won) begin
            motion_x_n = '0;
            motion_y_n = '0;
            state_n    = IDLE;
          end else if (!hit) begin
            state_n = MOVE;
          end else begin
            cur_dir_n  = NONE;
            motion_x_n = '0;
            motion_y_n = '0;
            state_n    = IDLE;
          end
        end
      end
      MOVE: begin
        pos_x_n       = tgt_x;
        pos_y_n       = tgt_y;
        motion_x_n    = q_unit.dx;
        motion_y_n    = q_unit.dy;
        step_strobe_n = 1'b1;
        state_n       = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cur_dir     <= NONE;
      want_dir    <= NONE;
      pos_x       <= START_X;
      pos_y       <= START_Y;
      motion_x    <= '0;
      motion_y    <= '0;
      step_strobe <= 1'b0;
    end else begin
      state       <= state_n;
      cur_dir     <= cur_dir_n;
      want_dir    <= key_to_dir(keycode);
      pos_x       <= pos_x_n;
      pos_y       <= pos_y_n;
      motion_x    <= motion_x_n;
      motion_y    <= motion_y_n;
      step_strobe <= step_strobe_n;
    end
  end

endmodule

// File: doc/pacman_move_ctrl.md
Name: pacman_move_ctrl

Overview:
- Sequences Pac-Man movement once per game step.
- Turns the held keycode into a desired direction and checks candidate tiles against the maze through a wall-query handshake.
- Updates the Pac-Man position and drives motion_x/motion_y to the animation FSM and the sprite renderer.
- Sits between the keyboard interface, the maze wall ROM port and the Pac-Man animation/drawing logic.

Parameters:
- STEP_DIV, 833333: clk cycles per movement step (60 Hz at 50 MHz); minimum 8.
- START_X, 10'd320: position X after reset.
- START_Y, 10'd360: position Y after reset.
- X_MIN, 10'd8: leftmost legal X.
- X_MAX, 10'd631: rightmost legal X.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- keycode  in  8  held USB HID keycode: 0x1A up, 0x16 down, 0x04 left, 0x07 right; any other value means no request.
- won  in  1  level; freezes movement.
- wq_valid  out  1  wall query request.
- wq_x  out  10  queried X; stable while wq_valid=1.
- wq_y  out  10  queried Y; stable while wq_valid=1.
- wq_ready  in  1  query accepted and answered this cycle.
- wq_wall  in  1  1 = wall at queried point; sampled only when wq_valid&&wq_ready.
- pos_x  out  10  Pac-Man X.
- pos_y  out  10  Pac-Man Y.
- motion_x  out  10  two's complement: -1, 0 or +1.
- motion_y  out  10  two's complement: -1, 0 or +1.
- step_strobe  out  1  one-cycle pulse, coincident with a pos update.

Behaviour:
- Reset values (async, reset_n=0): pos=START_X/START_Y, motion_x=motion_y=0, cur_dir=NONE, wq_valid=0, wq_x=wq_y=0, step_strobe=0, tick counter=0, state IDLE.
- Tick counter counts 0..STEP_DIV-1 and wraps. The wrap cycle raises tick for one cycle. The counter runs in every state.
- Direction decode: want_dir is a registered decode of keycode. An unmapped keycode leaves want_dir=NONE; cur_dir is kept.
- State IDLE:
  - On tick with won=0: if want_dir!=NONE and want_dir!=cur_dir, go to Q_WANT; else if cur_dir!=NONE, go to Q_CUR; else stay in IDLE.
  - On tick with won=1: force motion to 0 and stay in IDLE.
- State Q_WANT:
  - wq_valid=1; wq_x/wq_y = pos + unit(want_dir).
  - On handshake with wq_wall=0: cur_dir<=want_dir, go to MOVE.
  - On handshake with wq_wall=1: go to Q_CUR if cur_dir!=NONE; otherwise go to IDLE with motion 0.
- State Q_CUR:
  - wq_valid=1; query target = pos + unit(cur_dir).
  - On handshake with wq_wall=0: go to MOVE.
  - On handshake with wq_wall=1: cur_dir<=NONE, motion<=0, go to IDLE.
- State MOVE: pos<=pos+unit(cur_dir); motion<=unit(cur_dir); step_strobe<=1 for one cycle; go to IDLE.
- Latency with wq_ready tied high: tick at cycle T, query at T+1, MOVE at T+2, new pos and step_strobe visible at T+3. A Q_WANT miss followed by a Q_CUR hit adds 1 cycle.
- wq_valid stays asserted, with address stable, until accepted. There is no timeout.
- A tick arriving while the FSM is not in IDLE is dropped. One move per accepted tick at most.
- won rising while a query is in flight: the handshake completes, MOVE is suppressed, motion<=0, and the FSM returns to IDLE.
- Horizontal boundary: a target X outside [X_MIN,X_MAX] is treated as a wall without issuing a query. See the optional feature for the tunnel case.
- Vertical bounds rely on the maze walls only.
- Arithmetic: 10-bit, modulo 2^10. unit() is one of +1, -1 (10'h3FF), or 0.
- Reset mid-operation: wq_valid drops immediately; any pending response is ignored.

Optional Feature:
- Macro PACMAN_TUNNEL_WRAP_EN.
- Defined: a horizontal target beyond X_MAX becomes X_MIN, and one below X_MIN becomes X_MAX. The wrapped point is queried normally; on success pos jumps to it and motion keeps the travel sign (±1).
- Undefined: out-of-range X is treated as a wall, as described in Behaviour.

Decomposition:
- Shared package pacman_pkg holds:
  - dir_t enum: NONE, UP, DOWN, LEFT, RIGHT.
  - Keycode constants KEY_UP/KEY_DOWN/KEY_LEFT/KEY_RIGHT.
  - Function dir_unit(dir_t) returning signed dx/dy.
- The FSM state enum stays local to the module.
- One natural sub-module, step_tick_gen: parameterised divider producing the tick pulse.

Test Plan:
- Reset release, keycode=0x07, wq_ready=1, wq_wall=0: first tick queries (321,360); 2 cycles later pos_x=321, motion_x=+1, step_strobe one cycle.
- Moving right, keycode switches to 0x1A, wall above: Q_WANT returns wall, then Q_CUR for (322,360) is clear. Result: pos_x=322, motion_y stays 0, cur_dir stays RIGHT.
- Moving left, both queries report wall: motion_x=0, motion_y=0, pos unchanged; next tick with keycode=0 issues no query.
- wq_ready held low 5 cycles: wq_valid stays 1 with wq_x/wq_y constant, and a tick during the stall is dropped. After the grant, exactly one move occurs.
- won=1 asserted during Q_CUR: handshake completes, pos unchanged, motion becomes 0 next cycle, and later ticks issue no queries.
- pos_x=631 moving right: without PACMAN_TUNNEL_WRAP_EN, motion becomes 0 and no query is issued. With it defined, the query goes to (8,y) and pos_x=8 afterwards.
